regfile_access_ctrl: RTL and testbench
======================================

Name: regfile_access_ctrl

Overview:
- Sits between decode (read requester), writeback (write requester) and the CPU register_file instance.
- register_file can do one write or one read per cycle, and a write blocks reads in that cycle. This block arbitrates the single port between the two requesters with valid/ready handshakes.
- Write has priority, with a bounded-starvation guarantee for reads.
- Generates the read-response valid one cycle after grant.
- Optionally tracks pending destination registers through a scoreboard.

Parameters:
- reg_width, 5, register address width.
- data_width, 32, register data width.
- max_wb_streak, 4, consecutive writeback grants allowed while an eligible read waits; legal range 1-15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rd_req_valid  in  1  decode read request.
- rd_req_ready  out  1  read granted this cycle.
- rd_req_rs1  in  reg_width  source 1 address.
- rd_req_rs2  in  reg_width  source 2 address.
- rd_req_two  in  1  rs2 is also needed.
- rd_resp_valid  out  1  read data valid; no backpressure.
- rd_resp_rs1_data  out  data_width  source 1 data.
- rd_resp_rs2_data  out  data_width  source 2 data; 0 when rd_req_two was 0.
- wb_valid  in  1  writeback request.
- wb_ready  out  1  writeback accepted this cycle.
- wb_rd  in  reg_width  destination register.
- wb_data  in  data_width  write data.
- rf_rd_en, rf_rs1_en, rf_rs2_en  out  1 each  register_file enables.
- rf_rd, rf_rs1, rf_rs2  out  reg_width  register_file addresses.
- rf_rd_din  out  data_width  register_file write data.
- rf_rs1_dout, rf_rs2_dout  in  data_width  register_file read data.
- reserve_valid  in  1  mark a register pending (REGFILE_SCOREBOARD_EN only).
- reserve_rd  in  reg_width  register to mark pending (REGFILE_SCOREBOARD_EN only).

Behaviour:
- Reset: one clk, rst, synchronous active-high. At the next edge:
  - state=WB_PRIO, streak counter=0, rd_resp_valid=0, resp_two flag=0, scoreboard cleared.
  - Combinational outputs rd_req_ready, wb_ready and rf_* are forced 0 while rst=1.
  - Reset mid-transaction drops any in-flight response.
- Eligible read: rd_req_valid=1 and not blocked by the scoreboard.
- Writes to x0: wb_valid=1 with wb_rd=0 is accepted (wb_ready=1) with rf_rd_en=0. It consumes no port slot, so an eligible read may be granted in the same cycle. It does not affect the streak counter.
- Port grant is combinational in the cycle; register_file samples the enables at the following edge.
  - Write grant: rf_rd_en=1, rf_rd=wb_rd, rf_rd_din=wb_data.
  - Read grant: rf_rs1_en=1, rf_rs1=rd_req_rs1, rf_rs2_en=rd_req_two, rf_rs2=rd_req_rs2. The rs2-only read form is never issued.
- FSM, two states:
  - WB_PRIO: a real write (wb_rd!=0) wins.
    - If an eligible read lost, counter+1.
    - When the counter reaches max_wb_streak, the next state is RD_PRIO.
    - Any read grant, or no eligible read pending, clears the counter.
  - RD_PRIO: an eligible read wins and wb_ready=0 for that real write.
    - Then go to WB_PRIO with counter=0.
    - If no eligible read is present in RD_PRIO, a write may be granted; go to WB_PRIO with counter=0.
- Response:
  - rd_resp_valid is registered and asserted exactly one cycle after a read grant, for one cycle.
  - rd_resp_rs1_data = rf_rs1_dout.
  - rd_resp_rs2_data = rf_rs2_dout if the registered resp_two flag is set, else 0.
  - Back-to-back read grants give back-to-back valids.
- Write-then-read to the same register in consecutive cycles returns the new value; register_file ordering guarantees this.

Optional Feature:
- Macro REGFILE_SCOREBOARD_EN.
- Defined:
  - Adds the reserve ports and a 2**reg_width-bit pending vector.
  - reserve_valid with reserve_rd!=0 sets the bit.
  - An accepted write clears bit wb_rd.
  - A simultaneous set and clear of the same bit leaves it set.
  - x0 is never pending.
  - A read is blocked (rd_req_ready=0, not counted as eligible) when rs1 is pending, or when rd_req_two=1 and rs2 is pending.
  - A clear takes effect for reads from the next cycle.
- Undefined: no reserve ports, no pending state, every valid read is eligible.

Decomposition:
- Shared include header regfile_ctrl_defs.vh:
  - State encodings WB_PRIO=1'b0, RD_PRIO=1'b1.
  - Default reg_width and data_width.
- One natural sub-module, regfile_scoreboard: the pending vector, set/clear logic and a combinational blocked output. It is instantiated only under REGFILE_SCOREBOARD_EN.

Test Plan:
1. Reset with all inputs active -> all outputs 0 during rst; rd_resp_valid=0 the cycle after rst falls.
2. Read only, rs1=3, rs2=7, two=1, register 3=0x11 and register 7=0x22 -> grant in cycle T, rd_resp_valid at T+1 with 0x11/0x22. Repeat with two=0 -> rs2 data=0 and rf_rs2_en=0.
3. wb_valid held with wb_rd=5 plus a read held, max_wb_streak=4 -> 4 write grants, read granted in cycle 5, writes resume in cycle 6.
4. Write rd=0 and read issued together -> both wb_ready=1 and rd_req_ready=1 in the same cycle, rf_rd_en=0.
5. (SCOREBOARD) reserve rd=9; read rs1=9 -> stalls; write rd=9 data 0xAB -> read granted the next cycle and returns 0xAB.
6. Assert rst in the cycle after a read grant -> rd_resp_valid stays 0 and the FSM returns to WB_PRIO with counter=0.

Source files
------------

// File: rtl/regfile_access_ctrl_pkg.sv
// Shared types and defaults for the register-file port arbiter.
// State encodings are fixed so that debug probes can decode them directly.
package regfile_access_ctrl_pkg;

    localparam int DEF_REG_WIDTH  = 5;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int STREAK_W       = 4;

    typedef enum logic {
        WB_PRIO = 1'b0,
        RD_PRIO = 1'b1
    } arb_state_t;

    // Next streak value and whether it hits the configured limit.
    function automatic logic streak_at_limit(input logic [STREAK_W-1:0] streak,
                                             input int limit);
        return (streak + STREAK_W'(1)) == STREAK_W'(limit);
    endfunction

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Bundle of decode-read, writeback and register_file port signals.
// slave = arbiter view, master = requesters plus register_file view.
interface regfile_access_ctrl_if
    import regfile_access_ctrl_pkg::*;
#(
    parameter int reg_width  = DEF_REG_WIDTH,
    parameter int data_width = DEF_DATA_WIDTH
) ();
    logic                  rd_req_valid;
    logic                  rd_req_ready;
    logic [reg_width-1:0]  rd_req_rs1;
    logic [reg_width-1:0]  rd_req_rs2;
    logic                  rd_req_two;
    logic                  rd_resp_valid;
    logic [data_width-1:0] rd_resp_rs1_data;
    logic [data_width-1:0] rd_resp_rs2_data;

    logic                  wb_valid;
    logic                  wb_ready;
    logic [reg_width-1:0]  wb_rd;
    logic [data_width-1:0] wb_data;

    logic                  rf_rd_en;
    logic                  rf_rs1_en;
    logic                  rf_rs2_en;
    logic [reg_width-1:0]  rf_rd;
    logic [reg_width-1:0]  rf_rs1;
    logic [reg_width-1:0]  rf_rs2;
    logic [data_width-1:0] rf_rd_din;
    logic [data_width-1:0] rf_rs1_dout;
    logic [data_width-1:0] rf_rs2_dout;

`ifdef REGFILE_SCOREBOARD_EN
    logic                  reserve_valid;
    logic [reg_width-1:0]  reserve_rd;
`endif

    modport slave (
`ifdef REGFILE_SCOREBOARD_EN
        input  reserve_valid, reserve_rd,
`endif
        input  rd_req_valid, rd_req_rs1, rd_req_rs2, rd_req_two,
        output rd_req_ready, rd_resp_valid, rd_resp_rs1_data, rd_resp_rs2_data,
        input  wb_valid, wb_rd, wb_data,
        output wb_ready,
        output rf_rd_en, rf_rs1_en, rf_rs2_en, rf_rd, rf_rs1, rf_rs2, rf_rd_din,
        input  rf_rs1_dout, rf_rs2_dout
    );

    modport master (
`ifdef REGFILE_SCOREBOARD_EN
        output reserve_valid, reserve_rd,
`endif
        output rd_req_valid, rd_req_rs1, rd_req_rs2, rd_req_two,
        input  rd_req_ready, rd_resp_valid, rd_resp_rs1_data, rd_resp_rs2_data,
        output wb_valid, wb_rd, wb_data,
        input  wb_ready,
        input  rf_rd_en, rf_rs1_en, rf_rs2_en, rf_rd, rf_rs1, rf_rs2, rf_rd_din,
        output rf_rs1_dout, rf_rs2_dout
    );

endinterface

// File: rtl/regfile_access_ctrl_scoreboard.sv
// Pending-destination tracker: set on reserve, clear on accepted write, x0 never pending.
// Latency: set/clear visible to o_blocked from the next cycle; blocked output is combinational.
// Backpressure: none of its own; o_blocked stalls decode reads in the arbiter.
module regfile_scoreboard
    import regfile_access_ctrl_pkg::*;
#(
    parameter int reg_width = DEF_REG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_set_vld,
    input  logic [reg_width-1:0] i_set_idx,
    input  logic                 i_clr_vld,
    input  logic [reg_width-1:0] i_clr_idx,
    input  logic [reg_width-1:0] i_rs1,
    input  logic [reg_width-1:0] i_rs2,
    input  logic                 i_two,
    output logic                 o_blocked
);
    localparam int NREG = 2 ** reg_width;

    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_next;

    // Set is applied after clear so a same-cycle set and clear leaves the bit pending.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (i_set_vld) w_set[i_set_idx] = 1'b1;
        if (i_clr_vld) w_clr[i_clr_idx] = 1'b1;
        w_next    = (r_pending & ~w_clr) | w_set;
        w_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) r_pending <= '0;
        else     r_pending <= w_next;
    end

    assign o_blocked = r_pending[i_rs1] || (i_two && r_pending[i_rs2]);

endmodule

// File: rtl/regfile_access_ctrl.sv
// Arbitrates the single register_file port: writeback first, reads after max_wb_streak losses.
// Latency: grant combinational in the request cycle; rd_resp_valid one cycle after a read grant.
// Backpressure: rd_req_ready/wb_ready per cycle; response has none. Optional REGFILE_SCOREBOARD_EN.
module regfile_access_ctrl
    import regfile_access_ctrl_pkg::*;
#(
    parameter int reg_width     = DEF_REG_WIDTH,
    parameter int data_width    = DEF_DATA_WIDTH,
    parameter int max_wb_streak = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_access_ctrl_if.slave bus
);
    arb_state_t          r_state;
    logic [STREAK_W-1:0] r_streak;
    logic                r_resp_vld;
    logic                r_resp_two;

    logic w_blocked;
    logic w_wb_real;
    logic w_wb_x0;
    logic w_rd_elig;
    logic w_wr_grant;
    logic w_rd_grant;
    logic w_wb_acc;

`ifdef REGFILE_SCOREBOARD_EN
    regfile_scoreboard #(.reg_width(reg_width)) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .i_set_vld (bus.reserve_valid),
        .i_set_idx (bus.reserve_rd),
        .i_clr_vld (w_wb_acc),
        .i_clr_idx (bus.wb_rd),
        .i_rs1     (bus.rd_req_rs1),
        .i_rs2     (bus.rd_req_rs2),
        .i_two     (bus.rd_req_two),
        .o_blocked (w_blocked)
    );
`else
    assign w_blocked = 1'b0;
`endif

    assign w_wb_real = bus.wb_valid && (bus.wb_rd != '0);
    assign w_wb_x0   = bus.wb_valid && (bus.wb_rd == '0);
    assign w_rd_elig = bus.rd_req_valid && !w_blocked;

    always_comb begin
        w_wr_grant = 1'b0;
        w_rd_grant = 1'b0;
        if (!rst) begin
            if (r_state == RD_PRIO) begin
                w_rd_grant = w_rd_elig;
                w_wr_grant = w_wb_real && !w_rd_elig;
            end else begin
                w_wr_grant = w_wb_real;
                w_rd_grant = w_rd_elig && !w_wb_real;
            end
        end
    end

    // x0 writes are acknowledged without touching the port.
    assign w_wb_acc = w_wr_grant || (w_wb_x0 && !rst);

    assign bus.wb_ready     = w_wb_acc;
    assign bus.rd_req_ready = w_rd_grant;
    assign bus.rf_rd_en     = w_wr_grant;
    assign bus.rf_rd        = w_wr_grant ? bus.wb_rd : '0;
    assign bus.rf_rd_din    = w_wr_grant ? bus.wb_data : '0;
    assign bus.rf_rs1_en    = w_rd_grant;
    assign bus.rf_rs1       = w_rd_grant ? bus.rd_req_rs1 : '0;
    assign bus.rf_rs2_en    = w_rd_grant && bus.rd_req_two;
    assign bus.rf_rs2       = (w_rd_grant && bus.rd_req_two) ? bus.rd_req_rs2 : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= WB_PRIO;
            r_streak   <= '0;
            r_resp_vld <= 1'b0;
            r_resp_two <= 1'b0;
        end else begin
            r_resp_vld <= w_rd_grant;
            r_resp_two <= w_rd_grant && bus.rd_req_two;
            case (r_state)
                WB_PRIO: begin
                    if (w_wr_grant && w_rd_elig) begin
                        r_streak <= r_streak + STREAK_W'(1);
                        if (streak_at_limit(r_streak, max_wb_streak)) r_state <= RD_PRIO;
                    end else begin
                        r_streak <= '0;
                    end
                end
                RD_PRIO: begin
                    r_state  <= WB_PRIO;
                    r_streak <= '0;
                end
                default: begin
                    r_state  <= WB_PRIO;
                    r_streak <= '0;
                end
            endcase
        end
    end

    // A reset arriving while a response is in flight suppresses it immediately.
    assign bus.rd_resp_valid    = r_resp_vld && !rst;
    assign bus.rd_resp_rs1_data = bus.rf_rs1_dout;
    assign bus.rd_resp_rs2_data = r_resp_two ? bus.rf_rs2_dout : '0;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl with a behavioural register_file and a read-response scoreboard.
module tb_regfile_access_ctrl;
    import regfile_access_ctrl_pkg::*;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    exp_t        exp_q[$];
    logic [31:0] gold [0:31] = '{default: '0};
    logic [31:0] regs [0:31] = '{default: '0};

    regfile_access_ctrl_if #(.reg_width(5), .data_width(32)) bus ();

    regfile_access_ctrl #(.reg_width(5), .data_width(32), .max_wb_streak(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Behavioural register_file: samples enables at the edge, registered read data.
    always @(posedge clk) begin
        if (bus.rf_rd_en === 1'b1) regs[bus.rf_rd] <= bus.rf_rd_din;
        if (bus.rf_rs1_en === 1'b1) bus.rf_rs1_dout <= regs[bus.rf_rs1];
        if (bus.rf_rs2_en === 1'b1) bus.rf_rs2_dout <= regs[bus.rf_rs2];
    end

    // Scoreboard: expectation pushed at read acceptance, compared at response.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1) begin
            exp_q.delete();
        end else begin
            if (bus.rd_resp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_rs1", bus.rd_resp_rs1_data, e.rs1);
                    chk("resp_rs2", bus.rd_resp_rs2_data, e.rs2);
                end
            end
            if (bus.rd_req_ready === 1'b1) begin
                e.rs1 = gold[bus.rd_req_rs1];
                e.rs2 = bus.rd_req_two ? gold[bus.rd_req_rs2] : 32'd0;
                exp_q.push_back(e);
            end
            if (bus.wb_ready === 1'b1 && bus.wb_rd != 5'd0) gold[bus.wb_rd] = bus.wb_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] rd, input logic [31:0] d);
        logic got;
        got = 1'b0;
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd;
        bus.wb_data  = d;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.wb_ready === 1'b1) begin
                got = 1'b1;
                chk("wr_rf_en", 32'(bus.rf_rd_en), 32'(rd != 5'd0));
            end
            tick();
        end
        chk("wr_accept", 32'(got), 32'd1);
        bus.wb_valid = 1'b0;
    endtask

    task automatic read_once(input logic [4:0] rs1, input logic [4:0] rs2, input logic two);
        bus.rd_req_valid = 1'b1;
        bus.rd_req_rs1   = rs1;
        bus.rd_req_rs2   = rs2;
        bus.rd_req_two   = two;
        @(negedge clk);
        chk("rd_grant", 32'(bus.rd_req_ready), 32'd1);
        chk("rd_rs1_en", 32'(bus.rf_rs1_en), 32'd1);
        chk("rd_rs2_en", 32'(bus.rf_rs2_en), 32'(two));
        tick();
        bus.rd_req_valid = 1'b0;
        @(negedge clk);
        chk("rd_resp_vld", 32'(bus.rd_resp_valid), 32'd1);
        tick();
    endtask

    initial begin
        int nwr;
        logic done;
        // Reset with every request active.
        rst = 1'b1;
        bus.rd_req_valid = 1'b1; bus.rd_req_rs1 = 5'd3; bus.rd_req_rs2 = 5'd7; bus.rd_req_two = 1'b1;
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEAD_BEEF;
`ifdef REGFILE_SCOREBOARD_EN
        bus.reserve_valid = 1'b1; bus.reserve_rd = 5'd9;
`endif
        tick();
        @(negedge clk);
        chk("rst_rd_rdy", 32'(bus.rd_req_ready), 32'd0);
        chk("rst_wb_rdy", 32'(bus.wb_ready), 32'd0);
        chk("rst_rf_rd_en", 32'(bus.rf_rd_en), 32'd0);
        chk("rst_rf_rs1_en", 32'(bus.rf_rs1_en), 32'd0);
        chk("rst_rf_rs2_en", 32'(bus.rf_rs2_en), 32'd0);
        chk("rst_rf_rd", 32'(bus.rf_rd), 32'd0);
        chk("rst_rf_din", bus.rf_rd_din, 32'd0);
        chk("rst_resp_vld", 32'(bus.rd_resp_valid), 32'd0);
        tick();
        rst = 1'b0;
        bus.rd_req_valid = 1'b0; bus.wb_valid = 1'b0;
`ifdef REGFILE_SCOREBOARD_EN
        bus.reserve_valid = 1'b0;
`endif
        @(negedge clk);
        chk("post_rst_resp", 32'(bus.rd_resp_valid), 32'd0);
        tick();

        // Preload and two-source / single-source reads.
        do_write(5'd3, 32'h11);
        do_write(5'd7, 32'h22);
        read_once(5'd3, 5'd7, 1'b1);
        read_once(5'd3, 5'd7, 1'b0);

        // Write streak: four writes win, then the read, then writes again.
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd5;
        bus.rd_req_valid = 1'b1; bus.rd_req_rs1 = 5'd3; bus.rd_req_two = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.wb_data = 32'h100 + 32'(k);
            @(negedge clk);
            chk($sformatf("streak_wb%0d", k), 32'(bus.wb_ready), 32'(k != 4));
            chk($sformatf("streak_rd%0d", k), 32'(bus.rd_req_ready), 32'(k == 4));
            tick();
        end
        bus.wb_valid = 1'b0; bus.rd_req_valid = 1'b0;
        tick();

        // x0 write shares the cycle with a read.
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hCAFE;
        bus.rd_req_valid = 1'b1; bus.rd_req_rs1 = 5'd5; bus.rd_req_rs2 = 5'd3; bus.rd_req_two = 1'b1;
        @(negedge clk);
        chk("x0_wb_rdy", 32'(bus.wb_ready), 32'd1);
        chk("x0_rd_rdy", 32'(bus.rd_req_ready), 32'd1);
        chk("x0_rf_rd_en", 32'(bus.rf_rd_en), 32'd0);
        tick();
        bus.wb_valid = 1'b0; bus.rd_req_valid = 1'b0;
        tick();
        read_once(5'd0, 5'd0, 1'b1);

        // Write immediately followed by a read of the same register.
        do_write(5'd7, 32'h77);
        read_once(5'd7, 5'd3, 1'b1);

`ifdef REGFILE_SCOREBOARD_EN
        bus.reserve_valid = 1'b1; bus.reserve_rd = 5'd9;
        tick();
        bus.reserve_valid = 1'b0;
        bus.rd_req_valid = 1'b1; bus.rd_req_rs1 = 5'd9; bus.rd_req_two = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("sb_block", 32'(bus.rd_req_ready), 32'd0);
            tick();
        end
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'hAB;
        @(negedge clk);
        chk("sb_wb_rdy", 32'(bus.wb_ready), 32'd1);
        chk("sb_still_block", 32'(bus.rd_req_ready), 32'd0);
        tick();
        bus.wb_valid = 1'b0;
        @(negedge clk);
        chk("sb_release", 32'(bus.rd_req_ready), 32'd1);
        tick();
        bus.rd_req_valid = 1'b0;
        @(negedge clk);
        chk("sb_resp_vld", 32'(bus.rd_resp_valid), 32'd1);
        tick();
`endif

        // Reset right after a read grant drops the response and clears the streak.
        bus.rd_req_valid = 1'b1; bus.rd_req_rs1 = 5'd3; bus.rd_req_two = 1'b0;
        @(negedge clk);
        chk("rst6_grant", 32'(bus.rd_req_ready), 32'd1);
        tick();
        rst = 1'b1; bus.rd_req_valid = 1'b0;
        @(negedge clk);
        chk("rst6_resp_during", 32'(bus.rd_resp_valid), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst6_resp_after", 32'(bus.rd_resp_valid), 32'd0);
        tick();
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd6; bus.wb_data = 32'h66;
        bus.rd_req_valid = 1'b1; bus.rd_req_rs1 = 5'd6; bus.rd_req_two = 1'b0;
        nwr = 0; done = 1'b0;
        for (int k = 0; k < 12 && !done; k++) begin
            @(negedge clk);
            if (bus.rd_req_ready === 1'b1) done = 1'b1;
            else if (bus.wb_ready === 1'b1) nwr++;
            tick();
        end
        chk("rst6_read_seen", 32'(done), 32'd1);
        chk("rst6_streak", 32'(nwr), 32'd4);
        bus.wb_valid = 1'b0; bus.rd_req_valid = 1'b0;
        repeat (3) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
